// File: rtl/nd_wb_pkg.sv
// Shared Wishbone definitions: bus widths, the initiator FSM states and the
// default error word returned when a bus cycle is aborted.
package nd_wb_pkg;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  localparam logic [WB_DAT_W-1:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wb_timeout_ctr.sv
// 16-bit cycle counter with clear/enable; flags the cycle that would be the
// TIMEOUT_CYCLES-th counted cycle so the owner can abort on that same edge.
module wb_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  output logic [15:0] count,
  output logic        expired
);

  localparam logic [15:0] LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign count = count_q;
  // count_q already holds TIMEOUT_CYCLES-1 misses: the current one is the last allowed
  assign expired = (count_q >= LAST);

endmodule

// File: rtl/wb_cmd_master.sv
// Single-outstanding Wishbone classic initiator: valid/ready command stream in,
// one bus cycle per command, read data or timeout error out on a response stream.
module wb_cmd_master
  import nd_wb_pkg::*;
#(
  parameter int unsigned          TIMEOUT_CYCLES = 255,
  parameter logic [WB_DAT_W-1:0]  ERR_DATA       = ERR_DATA_DEFAULT
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_we_i,
  input  logic [WB_ADR_W-1:0] cmd_adr_i,
  input  logic [WB_DAT_W-1:0] cmd_dat_i,
  input  logic [WB_SEL_W-1:0] cmd_sel_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [WB_DAT_W-1:0] rsp_dat_o,
  output logic                rsp_err_o,
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic                wbm_we_o,
  output logic [WB_ADR_W-1:0] wbm_adr_o,
  output logic [WB_DAT_W-1:0] wbm_dat_o,
  output logic [WB_SEL_W-1:0] wbm_sel_o,
  input  logic [WB_DAT_W-1:0] wbm_dat_i,
  input  logic                wbm_ack_i
);

  wb_state_e           state_q, state_d;
  logic                load_cmd, ctr_clr, ctr_en, expired;
  logic [15:0]         ctr_count;
  logic                we_q;
  logic [WB_ADR_W-1:0] adr_q;
  logic [WB_DAT_W-1:0] dat_q;
  logic [WB_SEL_W-1:0] sel_q;
  logic [WB_DAT_W-1:0] rsp_dat_q, rsp_dat_d;
  logic                rsp_err_q, rsp_err_d;

  wb_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_ni),
    .clr     (ctr_clr),
    .en      (ctr_en),
    .count   (ctr_count),
    .expired (expired)
  );

  always_comb begin
    state_d   = state_q;
    load_cmd  = 1'b0;
    ctr_clr   = 1'b0;
    ctr_en    = 1'b0;
    rsp_dat_d = rsp_dat_q;
    rsp_err_d = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          state_d  = BUS;
          load_cmd = 1'b1;
          ctr_clr  = 1'b1;
        end
      end
      BUS: begin
        // ack is checked first so an ack on the expiry cycle completes normally
        if (wbm_ack_i) begin
          state_d   = RESP;
          rsp_dat_d = we_q ? '0 : wbm_dat_i;
          rsp_err_d = 1'b0;
        end else begin
          ctr_en = 1'b1;
          if (expired) begin
            state_d   = RESP;
            rsp_dat_d = ERR_DATA;
            rsp_err_d = 1'b1;
          end
        end
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      rsp_dat_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rsp_dat_q <= rsp_dat_d;
      rsp_err_q <= rsp_err_d;
      if (load_cmd) begin
        we_q  <= cmd_we_i;
        adr_q <= cmd_adr_i;
        dat_q <= cmd_dat_i;
        sel_q <= cmd_sel_i;
      end
    end
  end

  // All outputs decode flops only; bus fields hold their last command outside BUS
  assign cmd_ready_o = (state_q == IDLE);
  assign wbm_cyc_o   = (state_q == BUS);
  assign wbm_stb_o   = (state_q == BUS);
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_err_o   = rsp_err_q;
  assign wbm_we_o    = we_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;
  assign wbm_sel_o   = sel_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Bench for wb_cmd_master: table of directed transactions, random transactions
// against a response model, plus reset, stray-ack and backpressure sequences.
module tb_wb_cmd_master;

  localparam int TMO   = 8;
  localparam logic [31:0] ERRW = 32'hDEAD_BEEF;
  localparam int NEVER = 255;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_adr = '0, cmd_dat = '0;
  logic [3:0]  cmd_sel = '0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        cyc, stb, we_o;
  logic [31:0] adr_o, dat_o;
  logic [3:0]  sel_o;
  logic [31:0] rd_cfg = '0;
  logic        ack, stray_ack = 1'b0;
  int          ws_cfg = NEVER;
  int          stb_cnt = 0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Responder: acks once stb has been high for ws_cfg full cycles
  always @(posedge clk) begin
    if (!stb) stb_cnt <= 0;
    else      stb_cnt <= stb_cnt + 1;
  end
  assign ack = (stb && (stb_cnt == ws_cfg)) || stray_ack;

  wb_cmd_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_we_i    (cmd_we),
    .cmd_adr_i   (cmd_adr),
    .cmd_dat_i   (cmd_dat),
    .cmd_sel_i   (cmd_sel),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_dat_o   (rsp_dat),
    .rsp_err_o   (rsp_err),
    .wbm_cyc_o   (cyc),
    .wbm_stb_o   (stb),
    .wbm_we_o    (we_o),
    .wbm_adr_o   (adr_o),
    .wbm_dat_o   (dat_o),
    .wbm_sel_o   (sel_o),
    .wbm_dat_i   (rd_cfg),
    .wbm_ack_i   (ack)
  );

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] rd;
    int          ws;
    int          hold;
    logic [31:0] exp_dat;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: the ack edge is N+1+ws, the abort edge is N+TMO; the earlier one (ack on a tie) decides
  function automatic void model(input logic we, input logic [31:0] rd, input int ws,
                                output logic [31:0] d, output logic e, output int lat);
    if (ws <= TMO - 1) begin
      d = we ? 32'h0 : rd;
      e = 1'b0;
      lat = ws + 2;
    end else begin
      d = ERRW;
      e = 1'b1;
      lat = TMO + 1;
    end
  endfunction

  task automatic run_txn(input vec_t v, input string tag);
    int n, lat, stbc;
    logic bus_ok, ready_ok, stable_ok;
    logic [31:0] d0;
    logic e0;
    @(negedge clk);
    cmd_we = v.we; cmd_adr = v.adr; cmd_dat = v.dat; cmd_sel = v.sel;
    rd_cfg = v.rd; ws_cfg = v.ws; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      check({tag, " accept"}, 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 0; stbc = 0; bus_ok = 1'b1; ready_ok = 1'b1;
    while (1) begin
      lat++;
      if (stb) begin
        stbc++;
        if (!cyc || we_o !== v.we || adr_o !== v.adr || dat_o !== v.dat || sel_o !== v.sel) bus_ok = 1'b0;
      end
      if (cyc !== stb) bus_ok = 1'b0;
      if (rsp_valid || lat >= 100) break;
      if (cmd_ready) ready_ok = 1'b0;
      @(negedge clk);
    end
    check({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
    check({tag, " stb_cycles"}, 32'(stbc), 32'(v.exp_lat - 1));
    check({tag, " bus_fields"}, 32'(bus_ok), 32'd1);
    check({tag, " ready_low_in_bus"}, 32'(ready_ok), 32'd1);
    check({tag, " rsp_dat"}, rsp_dat, v.exp_dat);
    check({tag, " rsp_err"}, 32'(rsp_err), 32'(v.exp_err));
    d0 = rsp_dat; e0 = rsp_err; stable_ok = 1'b1;
    for (int i = 0; i < v.hold; i++) begin
      cmd_valid = 1'b1; stray_ack = 1'b1;
      @(negedge clk);
      if (!rsp_valid || rsp_dat !== d0 || rsp_err !== e0 || cmd_ready || stb) stable_ok = 1'b0;
    end
    cmd_valid = 1'b0; stray_ack = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    if (v.hold > 0) check({tag, " backpressure_hold"}, 32'(stable_ok), 32'd1);
    check({tag, " post_hs_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, " post_hs_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, " post_hs_stb"}, 32'(stb), 32'd0);
    check({tag, " adr_held"}, adr_o, v.adr);
  endtask

  vec_t tbl[7];

  initial begin
    vec_t r;
    bit seen;

    tbl[0] = '{1'b1, 32'h3000_0004, 32'h1234_5678, 4'hF, 32'h0,         0,     0, 32'h0,         1'b0, 2};
    tbl[1] = '{1'b0, 32'h3000_0010, 32'h0,         4'hF, 32'hA5A5_0001, 3,     0, 32'hA5A5_0001, 1'b0, 5};
    tbl[2] = '{1'b0, 32'h3000_0020, 32'h0,         4'h3, 32'h1111_2222, NEVER, 0, 32'hDEAD_BEEF, 1'b1, 9};
    tbl[3] = '{1'b0, 32'h3000_0024, 32'h0,         4'hF, 32'h0000_1111, 0,     0, 32'h0000_1111, 1'b0, 2};
    tbl[4] = '{1'b1, 32'h3000_0030, 32'hCAFE_F00D, 4'h5, 32'h9999_9999, 1,     5, 32'h0,         1'b0, 3};
    tbl[5] = '{1'b0, 32'h3000_0040, 32'h0,         4'hC, 32'h7777_0007, 7,     0, 32'h7777_0007, 1'b0, 9};
    tbl[6] = '{1'b0, 32'h3000_0044, 32'h0,         4'hF, 32'h8888_0008, 8,     2, 32'hDEAD_BEEF, 1'b1, 9};

    repeat (3) @(negedge clk);
    check("reset cmd_ready", 32'(cmd_ready), 32'd1);
    check("reset cyc_stb", {30'd0, cyc, stb}, 32'd0);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset rsp_dat", rsp_dat, 32'd0);
    check("reset rsp_err", 32'(rsp_err), 32'd0);
    check("reset bus_fields", adr_o | dat_o | {27'd0, we_o, sel_o}, 32'd0);
    rst_n = 1'b1;

    // Stray ack while idle must not produce a response
    @(negedge clk);
    stray_ack = 1'b1;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid || !cmd_ready) seen = 1'b1;
    end
    stray_ack = 1'b0;
    @(negedge clk);
    if (rsp_valid) seen = 1'b1;
    check("stray_ack_idle", 32'(seen), 32'd0);

    for (int i = 0; i < 7; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    // Reset two cycles into a bus cycle that would otherwise time out
    @(negedge clk);
    cmd_we = 1'b0; cmd_adr = 32'h3000_0050; cmd_sel = 4'hF; ws_cfg = NEVER; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_bus cyc_stb", {30'd0, cyc, stb}, 32'd0);
    check("rst_bus rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_bus ready_after", 32'(cmd_ready), 32'd1);
    seen = 1'b0;
    repeat (2 * TMO + 4) begin
      @(negedge clk);
      if (rsp_valid || stb) seen = 1'b1;
    end
    check("rst_bus no_response", 32'(seen), 32'd0);

    for (int i = 0; i < 40; i++) begin
      r.we   = 1'($urandom_range(0, 1));
      r.adr  = $urandom;
      r.dat  = $urandom;
      r.sel  = 4'($urandom_range(0, 15));
      r.rd   = $urandom;
      r.ws   = $urandom_range(0, 11);
      if (r.ws == 11) r.ws = NEVER;
      r.hold = $urandom_range(0, 3);
      model(r.we, r.rd, r.ws, r.exp_dat, r.exp_err, r.exp_lat);
      run_txn(r, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/wb_cmd_master.md
# wb_cmd_master

Single-outstanding Wishbone classic initiator that turns a valid/ready command stream into bus cycles toward the user project's `wbs_*` responder port. It returns read data, or a timeout error, on a valid/ready response stream. It sits between a command source (logic-analyzer probe bank or pad-driven debug logic) and the user design, so the user-side Wishbone responder can be exercised without the management SoC.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: cycles with STB asserted and no ACK before the cycle is aborted (1..65535).
- ERR_DATA, 32'hDEAD_BEEF: value placed on rsp_dat_o on timeout.

Ports. One clock; reset is asynchronous and active-low.
- wb_clk_i  in  1  clock
- wb_rst_ni  in  1  asynchronous active-low reset
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  command accepted when high with cmd_valid_i
- cmd_we_i  in  1  1 = write, 0 = read
- cmd_adr_i  in  32  byte address
- cmd_dat_i  in  32  write data
- cmd_sel_i  in  4  byte selects
- rsp_valid_o  out  1  response present
- rsp_ready_i  in  1  response consumed
- rsp_dat_o  out  32  read data; 0 for writes; ERR_DATA on timeout
- rsp_err_o  out  1  1 = timeout abort
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone master controls
- wbm_adr_o  out  32  address
- wbm_dat_o  out  32  write data
- wbm_sel_o  out  4  byte selects
- wbm_dat_i  in  32  read data from responder
- wbm_ack_i  in  1  responder acknowledge

## Operation
- FSM states are IDLE, BUS and RESP. Reset state is IDLE.
- IDLE:
  - cmd_ready_o = 1.
  - On cmd_valid_i & cmd_ready_o, register we/adr/dat/sel into the bus outputs, set cyc and stb, clear the timeout counter, and go to BUS.
- BUS:
  - cyc = stb = 1.
  - Bus outputs stay stable.
  - The counter increments each cycle that ack is not sampled.
  - On wbm_ack_i = 1:
    - drop cyc and stb;
    - capture rsp_dat_o = wbm_dat_i for reads, 0 for writes;
    - set rsp_err_o = 0 and rsp_valid_o = 1;
    - go to RESP.
  - When the counter reaches TIMEOUT_CYCLES with no ack:
    - drop cyc and stb;
    - set rsp_dat_o = ERR_DATA, rsp_err_o = 1, rsp_valid_o = 1;
    - go to RESP.
  - If ack and timeout coincide, ack wins and the response is normal.
- RESP:
  - rsp_* is held stable until rsp_valid_o & rsp_ready_i.
  - rsp_valid_o then clears and the FSM goes to IDLE.
  - cmd_ready_o = 0 throughout.
- wbm_ack_i sampled in IDLE or RESP is ignored (stray ack).
- wbm_we_o, wbm_adr_o, wbm_dat_o and wbm_sel_o keep their last values outside BUS. cyc and stb are low outside BUS.

## Timing
- Reset values: all outputs 0 except cmd_ready_o = 1 (IDLE). rsp_dat_o = 0.
- Reset asserted mid-cycle:
  - cyc, stb and rsp_valid_o clear asynchronously;
  - the pending command and response are discarded;
  - no response is ever produced for them.
- Command accepted at edge N: cyc/stb high after edge N.
- Zero-wait responder (ack combinational in the cycle after N): ack sampled at edge N+1, so cyc low and rsp_valid_o high after N+1.
- k wait states: rsp_valid_o high after edge N+1+k.
- Timeout:
  - cyc/stb are high for exactly TIMEOUT_CYCLES cycles;
  - rsp_valid_o rises on the edge on which cyc falls.
- rsp_ready_i held high: RESP lasts 1 cycle. Next cmd_ready_o is high the cycle after the response handshake.
- Maximum throughput is one transaction per 3 cycles (zero-wait).
- Registered outputs only; no combinational path from any input to any output.

## Structure
- Shared package nd_wb_pkg holds:
  - the state enum (IDLE/BUS/RESP);
  - WB_ADR_W = 32, WB_DAT_W = 32, WB_SEL_W = 4;
  - the default ERR_DATA constant.
- Sub-module wb_timeout_ctr: 16-bit counter with clear/enable and an `expired` flag comparing against TIMEOUT_CYCLES. It is reused by later Wishbone blocks.

## Test plan
- Write, zero-wait responder: cmd we=1 adr=0x3000_0004 dat=0x1234_5678 sel=0xF.
  - Expect one cycle of cyc/stb with those values on the bus.
  - Expect rsp_valid_o 2 cycles after acceptance with rsp_dat_o = 0, rsp_err_o = 0.
- Read, 3 wait states: responder returns 0xA5A5_0001.
  - Expect stb high 4 cycles and rsp_dat_o = 0xA5A5_0001.
  - Expect cmd_ready_o low until the response handshake.
- Timeout with TIMEOUT_CYCLES = 8 and no ack.
  - Expect cyc/stb high exactly 8 cycles, then rsp_err_o = 1 and rsp_dat_o = 0xDEAD_BEEF.
  - A following read completes normally.
- Backpressure: rsp_ready_i low for 5 cycles.
  - Expect rsp_* stable, cmd_ready_o = 0, and a second cmd_valid_i not accepted.
  - Accepted only after the handshake.
- Reset during BUS: assert wb_rst_ni low 2 cycles after acceptance.
  - Expect cyc/stb/rsp_valid_o at 0 immediately and cmd_ready_o = 1 after release.
  - No response is emitted.
- Stray ack in IDLE, plus ack on the timeout-expiry cycle.
  - Expect no response from the stray ack.
  - Expect a normal (err = 0) response for the coincident ack.
